// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, signed or unsigned.
// Define DIV_ZERO_FAST_EN to skip CALC when the divisor is zero.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvnd_q;
    logic             neg_quo_q, neg_rem_q, zero_q;

    logic             accept, last, fast_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    assign accept = (state_q == IDLE) && start && !flush;
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign busy   = (state_q == CALC);
    assign valid  = (state_q == DONE);

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (divisor == '0);
`else
    assign fast_zero = 1'b0;
`endif

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // Trial subtract is one bit wider so its sign bit is the borrow.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = fast_zero ? DONE : CALC;
                CALC:    if (last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvnd_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            dvnd_q    <= dividend;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            zero_q    <= (divisor == '0);
            if (fast_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == CALC && !flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                div_by_zero <= zero_q;
                if (zero_q) begin
                    quotient  <= '1;
                    remainder <= dvnd_q;
                end else begin
                    quotient  <= neg_quo_q ? -quo_nxt : quo_nxt;
                    remainder <= neg_rem_q ? -rem_nxt : rem_nxt;
                end
            end
        end
    end

endmodule
